// File: rtl/disparity_stream_scheduler.sv
// Pairs the disparity/confidence stream with the decimated gray stream into framed
// output beats (sof/eol/eof). One frame is armed per start pulse; frame_done marks the drained eof.
module disparity_stream_scheduler #(
    parameter int dec_factor = 2,
    parameter int frame_w    = 240,
    parameter int frame_h    = 480,
    parameter int disp_w     = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [disp_w-1:0] disp_data,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [7:0]        gray_data,
    input  logic              gray_valid,
    output logic              gray_ready,
    output logic [disp_w+7:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy,
    output logic              frame_done
);

    localparam int out_w = frame_w / dec_factor;
    localparam int out_h = frame_h / dec_factor;
    localparam int xw    = (out_w > 1) ? $clog2(out_w) : 1;
    localparam int yw    = (out_h > 1) ? $clog2(out_h) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [xw-1:0] x;
    logic [yw-1:0] y;
    logic          space;
    logic          fire;
    logic          arm;
    logic          x_last;
    logic          y_last;

    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        x_last    = (x == xw'(out_w - 1));
        y_last    = (y == yw'(out_h - 1));
        space     = !out_valid || out_ready;
        fire      = (state == RUN) && disp_valid && gray_valid && space;
        case (state)
            // frame_done is high during the first IDLE cycle; a start there is dropped
            IDLE: begin
                if (start && !frame_done) begin
                    state_nxt = RUN;
                    arm       = 1'b1;
                end
            end
            RUN: begin
                if (fire && x_last && y_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_valid && out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign disp_ready = fire;
    assign gray_ready = fire;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= (state == DRAIN) && out_valid && out_ready;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (arm) begin
            x <= '0;
            y <= '0;
        end else if (fire) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + yw'(1);
            end else begin
                x <= x + xw'(1);
            end
        end
    end

    // Single output register; data holds when the beat drains, only valid and markers clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (fire) begin
            out_data  <= {gray_data, disp_data};
            out_valid <= 1'b1;
            out_sof   <= (x == '0) && (y == '0);
            out_eol   <= x_last;
            out_eof   <= x_last && y_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_disparity_stream_scheduler.sv
// Scoreboard bench: the driver pushes each accepted input pair with its expected markers,
// the monitor pops and compares whenever the DUT hands a beat downstream.
module tb_disparity_stream_scheduler;

    localparam int DW   = 13;
    localparam int OW   = 120;
    localparam int OH   = 240;
    localparam int NPIX = OW * OH;

    typedef struct {
        logic [DW+7:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          disp_ready;
    logic [7:0]    gray_data;
    logic          gray_valid;
    logic          gray_ready;
    logic [DW+7:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sof;
    logic          out_eol;
    logic          out_eof;
    logic          busy;
    logic          frame_done;

    disparity_stream_scheduler #(
        .dec_factor(2),
        .frame_w(240),
        .frame_h(480),
        .disp_w(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .disp_data(disp_data),
        .disp_valid(disp_valid),
        .disp_ready(disp_ready),
        .gray_data(gray_data),
        .gray_valid(gray_valid),
        .gray_ready(gray_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sof(out_sof),
        .out_eol(out_eol),
        .out_eof(out_eof),
        .busy(busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];

    // Reference model of the frame: 0 idle, 1 run, 2 drain, 3 frame_done cycle
    int    bst = 0;
    int    p   = 0;
    int    k   = 0;
    bit    ov  = 1'b0;

    int    beat_cnt = 0;
    int    sof_cnt  = 0;
    int    eol_cnt  = 0;
    int    eof_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input bit dv, input bit gv, input bit ordy, input bit st);
        logic [DW+7:0] w;
        bit            fire_e;
        bit            last;
        w          = (DW + 8)'(k * 977 + 5);
        disp_valid = dv;
        gray_valid = gv;
        out_ready  = ordy;
        start      = st;
        disp_data  = w[DW-1:0];
        gray_data  = w[DW+7:DW];
        @(negedge clk);
        fire_e = (bst == 1) && dv && gv && (!ov || ordy);
        check("disp_ready", 32'(disp_ready), 32'(fire_e));
        check("gray_ready", 32'(gray_ready), 32'(fire_e));
        check("busy", 32'(busy), 32'(bst == 1 || bst == 2));
        check("frame_done", 32'(frame_done), 32'(bst == 3));
        last = (p == NPIX - 1);
        if (fire_e) begin
            exp_q.push_back('{w, (p == 0), ((p % OW) == OW - 1), last});
            k++;
            p = last ? 0 : p + 1;
        end
        case (bst)
            0: if (st) begin bst = 1; p = 0; end
            1: if (fire_e && last) bst = 2;
            2: if (ov && ordy) bst = 3;
            default: bst = 0;
        endcase
        ov = fire_e || (ov && !ordy);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_phase(input int cycles);
        reset      = 1'b1;
        bst        = 0;
        ov         = 1'b0;
        p          = 0;
        disp_valid = 1'b1;
        gray_valid = 1'b1;
        out_ready  = 1'b1;
        start      = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("rst_ctrl", 32'({out_valid, out_sof, out_eol, out_eof, busy, frame_done,
                                   disp_ready, gray_ready}), 32'd0);
            check("rst_data", 32'(out_data), 32'd0);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic clear_counts();
        beat_cnt = 0;
        sof_cnt  = 0;
        eol_cnt  = 0;
        eof_cnt  = 0;
    endtask

    task automatic check_frame_counts(input string tag);
        check({tag, "_beats"}, 32'(beat_cnt), 32'(NPIX));
        check({tag, "_sof"}, 32'(sof_cnt), 32'd1);
        check({tag, "_eol"}, 32'(eol_cnt), 32'(OH));
        check({tag, "_eof"}, 32'(eof_cnt), 32'd1);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compares every accepted output beat and checks hold-stability under backpressure
    bit            held = 1'b0;
    logic [DW+7:0] h_data;
    logic [2:0]    h_marks;

    always @(negedge clk) begin
        int    have;
        beat_t e;
        if (reset) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(h_data));
                check("hold_marks", 32'({out_sof, out_eol, out_eof}), 32'(h_marks));
            end
            if (!out_valid)
                check("idle_marks", 32'({out_sof, out_eol, out_eof}), 32'd0);
            if (out_valid && out_ready) begin
                have = exp_q.size();
                check("beat_pending", 32'(have > 0), 32'd1);
                if (have > 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(out_data), 32'(e.data));
                    check("beat_marks", 32'({out_sof, out_eol, out_eof}),
                          32'({e.sof, e.eol, e.eof}));
                end
                beat_cnt++;
                sof_cnt += int'(out_sof);
                eol_cnt += int'(out_eol);
                eof_cnt += int'(out_eof);
            end
            held    = out_valid && !out_ready;
            h_data  = out_data;
            h_marks = {out_sof, out_eol, out_eof};
        end
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        disp_valid = 1'b0;
        gray_valid = 1'b0;
        out_ready  = 1'b0;
        disp_data  = '0;
        gray_data  = '0;

        // Reset state with all inputs active
        reset_phase(3);

        // Streams valid before any start
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);

        // Frame 1: full throughput, stray starts mid-run, in drain and in the frame_done cycle
        clear_counts();
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < NPIX + 100 && bst != 3; c++)
            tick(1'b1, 1'b1, 1'b1, (bst == 1 && p == 500) || bst == 2);
        check("f1_done_reached", 32'(bst), 32'd3);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        check_frame_counts("f1");

        // Frame 2: back-to-back start, 1-in-3 disparity valid, stall mid-line, then reset at beat 1000
        clear_counts();
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 3000 && p < 600; c++) tick((c % 3) == 0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 200 && p < 650; c++) tick(1'b1, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 500 && p < 1000; c++) tick(1'b1, 1'b1, 1'b1, 1'b0);
        check("f2_progress", 32'(p), 32'd1000);
        reset_phase(2);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);

        // Frame 3: restarts from x=0,y=0 after the aborted frame
        clear_counts();
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < NPIX + 100 && bst != 3; c++) tick(1'b1, 1'b1, 1'b1, 1'b0);
        check("f3_done_reached", 32'(bst), 32'd3);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check_frame_counts("f3");
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
